// File: rtl/rns_reverse_conv_pkg.sv
// Shared RNS constants: moduli, modular-inverse shift, residue packing and FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rns_reverse_conv_pkg;

    localparam int RNS_MOD_A     = 129;
    localparam int RNS_MOD_B     = 256;
    localparam int RNS_INV_SHIFT = 6;
    localparam int RNS_OUT_WID   = 16;

    // Packing of one RNS value, identical to the RNS register file layout
    localparam int RNS_RA_MSB = 15;
    localparam int RNS_RA_LSB = 8;
    localparam int RNS_RB_MSB = 7;
    localparam int RNS_RB_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DBL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/rns_reverse_conv_if.sv
// Handshake bundle between an RNS producer/consumer (master) and the reverse converter (slave).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the input side and on the result side.
interface rns_reverse_conv_if;

    logic                                          in_valid;
    logic                                          in_ready;
    logic [rns_reverse_conv_pkg::RNS_OUT_WID-1:0]  rns_in;
    logic                                          out_valid;
    logic                                          out_ready;
    logic [rns_reverse_conv_pkg::RNS_OUT_WID-1:0]  bin_out;
    logic                                          busy;
    logic                                          err;

    modport master (
        output in_valid, rns_in, out_ready,
        input  in_ready, out_valid, bin_out, busy, err
    );

    modport slave (
        input  in_valid, rns_in, out_ready,
        output in_ready, out_valid, bin_out, busy, err
    );

endinterface

// File: rtl/rns_reverse_conv_mod_dbl.sv
// Modular doubling: t -> (2t mod MOD_A) for a canonical 8-bit residue t < MOD_A.
// Latency: combinational.
// Backpressure: none (pure function).
module rns_reverse_conv_mod_dbl
    import rns_reverse_conv_pkg::*;
#(
    parameter int MOD_A = RNS_MOD_A
) (
    input  logic [7:0] t_i,
    output logic [7:0] t_o
);

    localparam logic [8:0] MOD_A_U = 9'(MOD_A);

    logic [8:0] dbl;

    // 2t fits in 9 bits; one conditional subtract keeps the result canonical
    always_comb begin
        dbl = {t_i, 1'b0};
        t_o = (dbl >= MOD_A_U) ? 8'(dbl - MOD_A_U) : dbl[7:0];
    end

endmodule

// File: rtl/rns_reverse_conv.sv
// RNS {r_a mod 129, r_b mod 256} -> binary via X = r_b + 256*((r_a - r_b)*2^INV_SHIFT mod MOD_A).
// Latency: out_valid 1+INV_SHIFT edges after accept; 1 conversion per 2+INV_SHIFT cycles.
// Backpressure: result held in DONE until out_ready; in_ready also open in DONE when out_ready.
// Optional range check on r_a enabled by macro RNS_REVCONV_RANGE_CHK_EN (err tied 0 otherwise).
module rns_reverse_conv
    import rns_reverse_conv_pkg::*;
#(
    parameter int MOD_A     = RNS_MOD_A,
    parameter int INV_SHIFT = RNS_INV_SHIFT
) (
    input  logic                 clk,
    input  logic                 reset,
    rns_reverse_conv_if.slave    bus
);

    localparam int                CNT_W    = $clog2(INV_SHIFT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INV_SHIFT - 1);
    localparam logic [8:0]        MOD_A_U  = 9'(MOD_A);
    localparam logic signed [8:0] MOD_A_S  = 9'(MOD_A);

    state_e            state_q, state_d;
    logic [7:0]        t_q, t_d;
    logic [7:0]        ra_q, ra_d;
    logic [7:0]        rb_q, rb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       bin_q, bin_d;

    logic              in_ready_c;
    logic              capture;
    logic [8:0]        rb_wide;
    logic [7:0]        rb_m;
    logic signed [8:0] diff_s;
    logic [7:0]        sub_t;
    logic [7:0]        dbl_t;

    rns_reverse_conv_mod_dbl #(
        .MOD_A (MOD_A)
    ) u_mod_dbl (
        .t_i (t_q),
        .t_o (dbl_t)
    );

    // Modular subtraction (r_a - r_b) mod MOD_A; also folds a non-canonical r_a
    always_comb begin
        rb_wide = {1'b0, rb_q};
        rb_m    = (rb_wide >= MOD_A_U) ? 8'(rb_wide - MOD_A_U) : rb_q;
        diff_s  = $signed({1'b0, ra_q}) - $signed({1'b0, rb_m});
        if (diff_s < 0) begin
            sub_t = 8'(diff_s + MOD_A_S);
        end else if (diff_s >= MOD_A_S) begin
            sub_t = 8'(diff_s - MOD_A_S);
        end else begin
            sub_t = diff_s[7:0];
        end
    end

`ifdef RNS_REVCONV_RANGE_CHK_EN
    logic err_q, err_d;
`endif

    // Next-state and datapath update; a capture (IDLE or DONE retire) overrides the state arm
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
`ifdef RNS_REVCONV_RANGE_CHK_EN
        err_d   = err_q;
`endif
        in_ready_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
        capture    = bus.in_valid && in_ready_c;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SUB: begin
                t_d     = sub_t;
                cnt_d   = '0;
                state_d = ST_DBL;
            end
            ST_DBL: begin
                t_d   = dbl_t;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bin_d   = {dbl_t, rb_q};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
`ifdef RNS_REVCONV_RANGE_CHK_EN
                    err_d   = 1'b0;
`endif
                end
            end
        endcase

        if (capture) begin
            ra_d    = bus.rns_in[RNS_RA_MSB:RNS_RA_LSB];
            rb_d    = bus.rns_in[RNS_RB_MSB:RNS_RB_LSB];
            state_d = ST_SUB;
`ifdef RNS_REVCONV_RANGE_CHK_EN
            if ({1'b0, bus.rns_in[RNS_RA_MSB:RNS_RA_LSB]} >= MOD_A_U) begin
                bin_d   = '0;
                err_d   = 1'b1;
                state_d = ST_DONE;
            end
`endif
        end
    end

    // State and datapath registers; reset silently aborts any conversion in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
        end
    end

`ifdef RNS_REVCONV_RANGE_CHK_EN
    // Range-error flag, cleared when the flagged result is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.bin_out   = bin_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
